// File: rtl/rename_pkg.sv
// rename_pkg: shared widths, sentinel encodings and the renamed-instruction record for the rename stage.
package rename_pkg;
  localparam int MAX_OPERANDS = 3;
  localparam int ARN_BITS = 6;
  localparam int FU_COUNT = 4;
  localparam int FUC_BITS = $clog2(FU_COUNT);
  localparam int NUM_PREGS = 128;
  localparam int PRN_BITS = $clog2(NUM_PREGS);
  localparam int NUM_AREGS = 2 ** ARN_BITS;
  localparam int PTR_BITS = PRN_BITS + 1;
  localparam int CNT_BITS = $clog2(MAX_OPERANDS + 1);
  typedef logic [ARN_BITS-1:0] arn_t;
  typedef logic [PRN_BITS-1:0] prn_t;
  typedef logic [PTR_BITS-1:0] ptr_t;
  localparam arn_t ARN_NONE = '1;
  localparam prn_t PRN_NONE = '1;
  typedef struct packed {
    logic [31:0] raw;
    logic [63:0] pc;
    logic [FUC_BITS-1:0] fu_choice;
    prn_t [MAX_OPERANDS-1:0] prn_inputs;
    prn_t [MAX_OPERANDS-1:0] prn_outputs;
    prn_t [MAX_OPERANDS-1:0] prn_old;
  } renamed_instr_t;
  function automatic logic [CNT_BITS-1:0] pop_count(input logic [MAX_OPERANDS-1:0] v);
    pop_count = '0;
    for (int i = 0; i < MAX_OPERANDS; i++) pop_count = pop_count + CNT_BITS'(v[i]);
  endfunction
endpackage

// File: rtl/rename_stage_if.sv
// rename_stage_if: decode-side, dispatch-side, commit and flush signals of the rename stage.
interface rename_stage_if;
  import rename_pkg::*;
  logic in_valid, in_ready;
  logic [31:0] in_raw_instr;
  logic [63:0] in_pc;
  logic [FUC_BITS-1:0] in_fu_choice;
  arn_t [MAX_OPERANDS-1:0] in_arn_inputs, in_arn_outputs;
  logic out_valid, out_ready;
  logic [31:0] out_raw_instr;
  logic [63:0] out_pc;
  logic [FUC_BITS-1:0] out_fu_choice;
  prn_t [MAX_OPERANDS-1:0] out_prn_inputs, out_prn_outputs, out_prn_old;
  logic commit_valid;
  logic [MAX_OPERANDS-1:0] commit_dst_valid;
  arn_t [MAX_OPERANDS-1:0] commit_arn;
  prn_t [MAX_OPERANDS-1:0] commit_prn, commit_prn_old;
  logic flush;
  modport master (
    output in_valid, in_raw_instr, in_pc, in_fu_choice, in_arn_inputs, in_arn_outputs,
    output out_ready, commit_valid, commit_dst_valid, commit_arn, commit_prn, commit_prn_old, flush,
    input in_ready, out_valid, out_raw_instr, out_pc, out_fu_choice, out_prn_inputs, out_prn_outputs, out_prn_old
  );
  modport slave (
    input in_valid, in_raw_instr, in_pc, in_fu_choice, in_arn_inputs, in_arn_outputs,
    input out_ready, commit_valid, commit_dst_valid, commit_arn, commit_prn, commit_prn_old, flush,
    output in_ready, out_valid, out_raw_instr, out_pc, out_fu_choice, out_prn_inputs, out_prn_outputs, out_prn_old
  );
endinterface

// File: rtl/rename_stage_free_list.sv
// free_list: circular PRN pool with multi-pop at head, multi-push at tail and a committed-head checkpoint.
module free_list
  import rename_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic [CNT_BITS-1:0] pop_n_i,
  input  logic [MAX_OPERANDS-1:0] push_v_i,
  input  prn_t [MAX_OPERANDS-1:0] push_prn_i,
  input  logic flush_i,
  output prn_t [MAX_OPERANDS-1:0] peek_o,
  output ptr_t count_o
);
  prn_t mem_q [NUM_PREGS];
  ptr_t head_q, chead_q, tail_q, head_d, chead_d;
  prn_t widx [MAX_OPERANDS];
  prn_t w;
  logic [CNT_BITS-1:0] push_n;
  assign count_o = tail_q - head_q;
  always_comb begin
    push_n = pop_count(push_v_i);
    chead_d = chead_q + PTR_BITS'(push_n);
    head_d = flush_i ? chead_d : head_q + PTR_BITS'(pop_n_i);
    w = tail_q[PRN_BITS-1:0];
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      peek_o[k] = mem_q[head_q[PRN_BITS-1:0] + PRN_BITS'(k)];
      widx[k] = w;
      w = w + PRN_BITS'(push_v_i[k]);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREGS; i++) mem_q[i] <= i < NUM_AREGS ? PRN_BITS'(NUM_AREGS + i) : '0;
      head_q <= '0;
      chead_q <= '0;
      tail_q <= PTR_BITS'(NUM_PREGS - NUM_AREGS);
    end else begin
      for (int k = 0; k < MAX_OPERANDS; k++) if (push_v_i[k]) mem_q[widx[k]] <= push_prn_i[k];
      head_q <= head_d;
      chead_q <= chead_d;
      tail_q <= tail_q + PTR_BITS'(push_n);
    end
  end
  assert property (@(posedge clk) disable iff (rst) count_o <= PTR_BITS'(NUM_PREGS));
endmodule

// File: rtl/rename_stage.sv
// rename_stage: maps ARNs to PRNs through a speculative RAT, a retirement RAT and a free list.
module rename_stage
  import rename_pkg::*;
(
  input logic clk,
  input logic rst,
  rename_stage_if.slave io
);
  prn_t spec_rat_q [NUM_AREGS];
  prn_t ret_rat_q [NUM_AREGS];
  prn_t ret_rat_d [NUM_AREGS];
  renamed_instr_t out_q, out_d;
  logic out_valid_q, accept;
  logic [MAX_OPERANDS-1:0] used, push_v;
  logic [CNT_BITS-1:0] k;
  prn_t [MAX_OPERANDS-1:0] peek;
  ptr_t count;
  assign io.in_ready = count >= PTR_BITS'(MAX_OPERANDS) && (!out_valid_q || io.out_ready) && !io.flush;
  assign accept = io.in_valid && io.in_ready;
  assign push_v = {MAX_OPERANDS{io.commit_valid}} & io.commit_dst_valid;
  free_list u_free_list (
    .clk(clk), .rst(rst),
    .pop_n_i(accept ? pop_count(used) : CNT_BITS'(0)),
    .push_v_i(push_v), .push_prn_i(io.commit_prn_old),
    .flush_i(io.flush), .peek_o(peek), .count_o(count)
  );
  always_comb
    for (int j = 0; j < MAX_OPERANDS; j++) used[j] = io.in_arn_outputs[j] != ARN_NONE;
  // Sources see the RAT before this instruction's own destination writes.
  always_comb begin
    out_d = '0;
    out_d.raw = io.in_raw_instr;
    out_d.pc = io.in_pc;
    out_d.fu_choice = io.in_fu_choice;
    k = '0;
    for (int j = 0; j < MAX_OPERANDS; j++) begin
      out_d.prn_inputs[j] = io.in_arn_inputs[j] == ARN_NONE ? PRN_NONE : spec_rat_q[io.in_arn_inputs[j]];
      out_d.prn_outputs[j] = used[j] ? peek[k] : PRN_NONE;
      out_d.prn_old[j] = used[j] ? spec_rat_q[io.in_arn_outputs[j]] : PRN_NONE;
      k = k + CNT_BITS'(used[j]);
    end
  end
  always_comb begin
    ret_rat_d = ret_rat_q;
    for (int j = 0; j < MAX_OPERANDS; j++) if (push_v[j]) ret_rat_d[io.commit_arn[j]] = io.commit_prn[j];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_AREGS; i++) begin
        spec_rat_q[i] <= PRN_BITS'(i);
        ret_rat_q[i] <= PRN_BITS'(i);
      end
      out_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ret_rat_q <= ret_rat_d;
      if (io.flush) begin
        spec_rat_q <= ret_rat_d;
        out_valid_q <= 1'b0;
      end else if (accept) begin
        for (int j = 0; j < MAX_OPERANDS; j++) if (used[j]) spec_rat_q[io.in_arn_outputs[j]] <= out_d.prn_outputs[j];
        out_q <= out_d;
        out_valid_q <= 1'b1;
      end else if (io.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end
  assign io.out_valid = out_valid_q;
  assign io.out_raw_instr = out_q.raw;
  assign io.out_pc = out_q.pc;
  assign io.out_fu_choice = out_q.fu_choice;
  assign io.out_prn_inputs = out_q.prn_inputs;
  assign io.out_prn_outputs = out_q.prn_outputs;
  assign io.out_prn_old = out_q.prn_old;
endmodule

// File: tb/tb_rename_stage.sv
// tb_rename_stage: table vectors plus a RAT/free-list reference model feeding an expected-output queue.
module tb_rename_stage;
  import rename_pkg::*;
  localparam int N = 63;
  localparam int P = 127;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rename_stage_if io ();
  rename_stage dut (.clk(clk), .rst(rst), .io(io));
  int checks = 0;
  int fails = 0;
  int rat [NUM_AREGS];
  int ret [NUM_AREGS];
  int fl [NUM_PREGS];
  int head, chead, tail;
  bit mv;
  renamed_instr_t exp_q [$];
  typedef struct {
    int ai [3];
    int ao [3];
    int ei [3];
    int eo [3];
    int eold [3];
  } vec_t;
  vec_t tbl [6];

  function automatic void chk(string n, logic [255:0] a, logic [255:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, a, e, $time);
    end
  endfunction

  function automatic renamed_instr_t dut_out();
    dut_out = {io.out_raw_instr, io.out_pc, io.out_fu_choice, io.out_prn_inputs, io.out_prn_outputs, io.out_prn_old};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_AREGS; i++) begin
      rat[i] = i;
      ret[i] = i;
    end
    for (int i = 0; i < NUM_PREGS; i++) fl[i] = i < NUM_AREGS ? NUM_AREGS + i : 0;
    head = 0;
    chead = 0;
    tail = NUM_PREGS - NUM_AREGS;
    mv = 0;
    exp_q.delete();
  endtask

  // One clock: drive, check ready/output against the model, advance the model, pass the edge.
  task automatic cycle(input bit req);
    bit rdy;
    renamed_instr_t e;
    int a;
    rdy = (tail - head >= MAX_OPERANDS) && (!mv || io.out_ready) && !io.flush;
    io.in_valid = req && rdy;
    #1;
    chk("in_ready", 256'(io.in_ready), 256'(rdy));
    chk("out_valid", 256'(io.out_valid), 256'(mv));
    if (mv) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL scoreboard_empty got=valid want=queued_entry t=%0t", $time);
      end else begin
        chk("out_payload", 256'(dut_out()), 256'(exp_q[0]));
        if (io.out_ready) void'(exp_q.pop_front());
      end
    end
    if (io.commit_valid)
      for (int j = 0; j < MAX_OPERANDS; j++)
        if (io.commit_dst_valid[j]) begin
          ret[io.commit_arn[j]] = io.commit_prn[j];
          fl[tail % NUM_PREGS] = io.commit_prn_old[j];
          tail++;
          chead++;
        end
    if (io.flush) begin
      rat = ret;
      head = chead;
      mv = 0;
      exp_q.delete();
    end else if (io.in_valid) begin
      e.raw = io.in_raw_instr;
      e.pc = io.in_pc;
      e.fu_choice = io.in_fu_choice;
      for (int j = 0; j < MAX_OPERANDS; j++)
        e.prn_inputs[j] = io.in_arn_inputs[j] == ARN_NONE ? PRN_NONE : prn_t'(rat[io.in_arn_inputs[j]]);
      for (int j = 0; j < MAX_OPERANDS; j++) begin
        a = io.in_arn_outputs[j];
        if (a == N) begin
          e.prn_outputs[j] = PRN_NONE;
          e.prn_old[j] = PRN_NONE;
        end else begin
          e.prn_outputs[j] = prn_t'(fl[head % NUM_PREGS]);
          e.prn_old[j] = prn_t'(rat[a]);
          rat[a] = fl[head % NUM_PREGS];
          head++;
        end
      end
      exp_q.push_back(e);
      mv = 1;
    end else if (io.out_ready) begin
      mv = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input int ai [3], input int ao [3]);
    io.in_raw_instr = $urandom;
    io.in_pc = {$urandom, $urandom};
    io.in_fu_choice = FUC_BITS'($urandom);
    for (int j = 0; j < MAX_OPERANDS; j++) begin
      io.in_arn_inputs[j] = arn_t'(ai[j]);
      io.in_arn_outputs[j] = arn_t'(ao[j]);
    end
    cycle(1);
  endtask

  task automatic commit1(input int arn, input int prn, input int old, input bit fl_en);
    io.commit_valid = 1'b1;
    io.commit_dst_valid = 3'b001;
    io.commit_arn[0] = arn_t'(arn);
    io.commit_prn[0] = prn_t'(prn);
    io.commit_prn_old[0] = prn_t'(old);
    io.flush = fl_en;
    cycle(0);
    io.commit_valid = 1'b0;
    io.commit_dst_valid = '0;
    io.flush = 1'b0;
  endtask

  task automatic hard_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_out_valid", 256'(io.out_valid), 256'(0));
    chk("async_rst_payload", 256'(dut_out()), 256'(0));
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  always @(posedge clk)
    if (!rst && io.in_valid && io.in_ready)
      for (int a = 0; a < MAX_OPERANDS; a++)
        for (int b = a + 1; b < MAX_OPERANDS; b++)
          assert (io.in_arn_outputs[a] == ARN_NONE || io.in_arn_outputs[a] != io.in_arn_outputs[b])
          else begin
            fails++;
            $display("FAIL dup_dst got=%0d want=distinct", io.in_arn_outputs[a]);
          end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    io.in_valid = 0;
    io.in_raw_instr = 0;
    io.in_pc = 0;
    io.in_fu_choice = 0;
    io.in_arn_inputs = '1;
    io.in_arn_outputs = '1;
    io.out_ready = 1;
    io.commit_valid = 0;
    io.commit_dst_valid = 0;
    io.commit_arn = 0;
    io.commit_prn = 0;
    io.commit_prn_old = 0;
    io.flush = 0;
    tbl[0] = '{ai:'{1,2,N}, ao:'{3,N,N}, ei:'{1,2,P},    eo:'{64,P,P},   eold:'{3,P,P}};
    tbl[1] = '{ai:'{3,N,N}, ao:'{N,N,N}, ei:'{64,P,P},   eo:'{P,P,P},    eold:'{P,P,P}};
    tbl[2] = '{ai:'{N,N,N}, ao:'{3,N,N}, ei:'{P,P,P},    eo:'{65,P,P},   eold:'{64,P,P}};
    tbl[3] = '{ai:'{3,4,5}, ao:'{4,5,6}, ei:'{65,4,5},   eo:'{66,67,68}, eold:'{4,5,6}};
    tbl[4] = '{ai:'{4,5,6}, ao:'{N,7,N}, ei:'{66,67,68}, eo:'{P,69,P},   eold:'{P,7,P}};
    tbl[5] = '{ai:'{0,7,N}, ao:'{N,N,0}, ei:'{0,69,P},   eo:'{P,P,70},   eold:'{P,P,0}};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 256'(io.out_valid), 256'(0));
    chk("rst_payload", 256'(dut_out()), 256'(0));
    chk("rst_in_ready", 256'(io.in_ready), 256'(1));
    rst = 1'b0;
    for (int v = 0; v < 6; v++) begin
      ins(tbl[v].ai, tbl[v].ao);
      for (int j = 0; j < MAX_OPERANDS; j++) begin
        chk($sformatf("tbl%0d_src%0d", v, j), 256'(io.out_prn_inputs[j]), 256'(tbl[v].ei[j]));
        chk($sformatf("tbl%0d_dst%0d", v, j), 256'(io.out_prn_outputs[j]), 256'(tbl[v].eo[j]));
        chk($sformatf("tbl%0d_old%0d", v, j), 256'(io.out_prn_old[j]), 256'(tbl[v].eold[j]));
      end
    end
    cycle(0);
    hard_reset();
    repeat (4) ins('{N,N,N}, '{5,N,N});
    commit1(5, 64, 5, 1'b1);
    ins('{5,N,N}, '{1,N,N});
    chk("flush_src", 256'(io.out_prn_inputs[0]), 256'(64));
    chk("flush_alloc", 256'(io.out_prn_outputs[0]), 256'(65));
    ins('{1,N,N}, '{2,N,N});
    io.out_ready = 1'b0;
    repeat (5) ins('{2,N,N}, '{3,N,N});
    io.out_ready = 1'b1;
    ins('{2,N,N}, '{3,N,N});
    chk("bp_src", 256'(io.out_prn_inputs[0]), 256'(66));
    chk("bp_alloc", 256'(io.out_prn_outputs[0]), 256'(67));
    cycle(0);
    io.out_ready = 1'b0;
    ins('{N,N,N}, '{9,N,N});
    hard_reset();
    io.out_ready = 1'b1;
    ins('{5,9,40}, '{N,N,N});
    chk("ident_x5", 256'(io.out_prn_inputs[0]), 256'(5));
    chk("ident_x9", 256'(io.out_prn_inputs[1]), 256'(9));
    chk("ident_x40", 256'(io.out_prn_inputs[2]), 256'(40));
    for (int i = 0; i < 62; i++) ins('{N,N,N}, '{i % 60,N,N});
    chk("exhaust_ready", 256'(io.in_ready), 256'(0));
    commit1(3, 64, 3, 1'b0);
    chk("refill_ready", 256'(io.in_ready), 256'(1));
    ins('{N,N,N}, '{7,N,N});
    chk("refill_alloc", 256'(io.out_prn_outputs[0]), 256'(126));
    cycle(0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
